// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: stall bus patterns,
// flush FSM state codes and the priority stall-merge function.
package pipe_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;

    // Stall bus bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB.
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_IF   = 6'b000011;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;

    typedef enum logic {
        PC_IDLE     = 1'b0,
        PC_REDIRECT = 1'b1
    } pc_state_e;

    // The deepest requester wins; a stage stall also holds every stage upstream of it.
    function automatic stall_bus_t merge_stall(input logic r_if, input logic r_id,
                                               input logic r_ex, input logic r_mem);
        stall_bus_t s;
        if (r_mem)      s = STALL_MEM;
        else if (r_ex)  s = STALL_EX;
        else if (r_id)  s = STALL_ID;
        else if (r_if)  s = STALL_IF;
        else            s = STALL_NONE;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter for performance debug; freezes when rdy=0 and
// sticks at its all-ones value.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (rdy && inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences EX
// mispredicts into a flush plus PC redirect to IF, and keeps perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_if,
    input  logic              req_id,
    input  logic              req_ex,
    input  logic              req_mem,
    input  logic              ex_mispredict,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              redirect_ack,
    output logic [5:0]        stall,
    output logic              br,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic [CNT_W-1:0]  cnt_mispredict,
    output logic [CNT_W-1:0]  cnt_stall,
    output pc_state_e         fsm_state
);

    // Redirect handshake: redirect_valid/redirect_addr stay asserted and stable
    // until a cycle with redirect_ack=1 (and rdy=1); that cycle completes the transfer.

    pc_state_e state;
    logic      accept;

    always_comb begin
        stall  = merge_stall(req_if, req_id, req_ex, req_mem);
        // A mispredict under an EX stall is left for EX to re-present later.
        accept = (state == PC_IDLE) && ex_mispredict && !stall[3];
        br     = accept || (state == PC_REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= PC_IDLE;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else if (rdy) begin
            case (state)
                PC_IDLE: begin
                    if (accept) begin
                        redirect_addr  <= ex_target;
                        redirect_valid <= 1'b1;
                        state          <= PC_REDIRECT;
                    end
                end
                PC_REDIRECT: begin
                    // EX holds only squashed ops here, so ex_mispredict is ignored.
                    if (redirect_ack) begin
                        redirect_valid <= 1'b0;
                        state          <= PC_IDLE;
                    end
                end
                default: begin
                    redirect_valid <= 1'b0;
                    state          <= PC_IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_mispredict (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .inc   (accept),
        .count (cnt_mispredict)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .inc   (|stall),
        .count (cnt_stall)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl, built with CNT_W=4 so counter saturation is
// reachable in a few cycles.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              req_if, req_id, req_ex, req_mem;
    logic              ex_mispredict;
    logic [ADDR_W-1:0] ex_target;
    logic              redirect_ack;
    logic [5:0]        stall;
    logic              br;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [CNT_W-1:0]  cnt_mispredict;
    logic [CNT_W-1:0]  cnt_stall;
    pc_state_e         fsm_state;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .req_if         (req_if),
        .req_id         (req_id),
        .req_ex         (req_ex),
        .req_mem        (req_mem),
        .ex_mispredict  (ex_mispredict),
        .ex_target      (ex_target),
        .redirect_ack   (redirect_ack),
        .stall          (stall),
        .br             (br),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .cnt_mispredict (cnt_mispredict),
        .cnt_stall      (cnt_stall),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy           = 1'b1;
        req_if        = 1'b0;
        req_id        = 1'b0;
        req_ex        = 1'b0;
        req_mem       = 1'b0;
        ex_mispredict = 1'b0;
        ex_target     = '0;
        redirect_ack  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rv: got %b want 0", redirect_valid);
        end
        checks++;
        if (redirect_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", redirect_addr);
        end
        checks++;
        if (cnt_mispredict !== 4'h0 || cnt_stall !== 4'h0) begin
            errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", cnt_mispredict, cnt_stall);
        end
        checks++;
        if (fsm_state !== PC_IDLE || br !== 1'b0 || stall !== 6'b000000) begin
            errors++; $display("FAIL reset_comb: state %0d br %b stall %b want 0 0 000000",
                               fsm_state, br, stall);
        end
    endtask

    task automatic test_stall_merge();
        // {req_mem, req_ex, req_id, req_if} -> expected bus
        logic [3:0] reqs [6];
        logic [5:0] exp  [6];
        reqs[0] = 4'b0010; exp[0] = 6'b000111;
        reqs[1] = 4'b0000; exp[1] = 6'b000000;
        reqs[2] = 4'b0001; exp[2] = 6'b000011;
        reqs[3] = 4'b0100; exp[3] = 6'b001111;
        reqs[4] = 4'b0111; exp[4] = 6'b001111;
        reqs[5] = 4'b1011; exp[5] = 6'b011111;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            {req_mem, req_ex, req_id, req_if} = reqs[i];
            #1;
            checks++;
            if (stall !== exp[i] || br !== 1'b0) begin
                errors++; $display("FAIL stall_merge[%0d]: got stall %b br %b want %b 0",
                                   i, stall, br, exp[i]);
            end
        end
        req_mem = 0; req_ex = 0; req_if = 0; req_id = 1'b1;
        #1;
        checks++;
        if (!(stall[2] && !stall[3])) begin
            errors++; $display("FAIL id_bubble: got stall %b want ID held and EX free", stall);
        end
        idle_inputs();
    endtask

    task automatic test_stall_count();
        do_reset();
        req_if = 1'b1; req_mem = 1'b1;
        #1;
        checks++;
        if (stall !== 6'b011111) begin
            errors++; $display("FAIL stall_mem_if: got %b want 011111", stall);
        end
        tick(); tick(); tick();
        checks++;
        if (cnt_stall !== 4'd3) begin
            errors++; $display("FAIL cnt_stall_run: got %0d want 3", cnt_stall);
        end
        rdy = 1'b0;
        ex_mispredict = 1'b1;
        ex_target = 32'h0000_0bad;
        tick(); tick();
        checks++;
        if (cnt_stall !== 4'd3 || fsm_state !== PC_IDLE || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL rdy_freeze: got cnt %0d state %0d rv %b want 3 0 0",
                               cnt_stall, fsm_state, redirect_valid);
        end
        idle_inputs();
        // Hold a stall long enough to pass the 4-bit ceiling.
        req_if = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (cnt_stall !== 4'hF) begin
            errors++; $display("FAIL cnt_stall_sat: got %h want F", cnt_stall);
        end
        idle_inputs();
    endtask

    task automatic test_flush_sequence();
        int br_cycles = 0;
        int rv_cycles = 0;
        do_reset();
        for (int cyc = 0; cyc < 7; cyc++) begin
            ex_mispredict = (cyc == 0);
            ex_target     = (cyc == 0) ? 32'h0000_1040 : 32'hdead_beef;
            redirect_ack  = (cyc == 4);
            #1;
            if (br) br_cycles++;
            if (redirect_valid) begin
                rv_cycles++;
                checks++;
                if (redirect_addr !== 32'h0000_1040) begin
                    errors++; $display("FAIL redirect_addr[%0d]: got %h want 00001040",
                                       cyc, redirect_addr);
                end
            end
            tick();
        end
        checks++;
        if (br_cycles != 5) begin
            errors++; $display("FAIL br_len: got %0d want 5", br_cycles);
        end
        checks++;
        if (rv_cycles != 4) begin
            errors++; $display("FAIL rv_len: got %0d want 4", rv_cycles);
        end
        checks++;
        if (cnt_mispredict !== 4'd1 || fsm_state !== PC_IDLE) begin
            errors++; $display("FAIL flush_end: got cnt %0d state %0d want 1 0",
                               cnt_mispredict, fsm_state);
        end
        idle_inputs();
    endtask

    task automatic test_mispredict_under_stall();
        do_reset();
        ex_mispredict = 1'b1;
        ex_target = 32'h0000_3000;
        req_ex = 1'b1;
        for (int cyc = 0; cyc < 2; cyc++) begin
            #1;
            checks++;
            if (br !== 1'b0 || redirect_valid !== 1'b0) begin
                errors++; $display("FAIL stalled_mp[%0d]: got br %b rv %b want 0 0",
                                   cyc, br, redirect_valid);
            end
            tick();
        end
        req_ex = 1'b0;
        #1;
        checks++;
        if (br !== 1'b1) begin
            errors++; $display("FAIL accept_3rd: got br %b want 1", br);
        end
        tick();
        ex_mispredict = 1'b0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_addr !== 32'h0000_3000 || cnt_mispredict !== 4'd1) begin
            errors++; $display("FAIL redirect_3rd: got rv %b addr %h cnt %0d want 1 00003000 1",
                               redirect_valid, redirect_addr, cnt_mispredict);
        end
        redirect_ack = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_mispredict = 1'b1;
        ex_target = 32'h0000_0100;
        tick();
        // In REDIRECT: ack plus a fresh mispredict; only the ack takes effect.
        ex_target = 32'h0000_0200;
        redirect_ack = 1'b1;
        tick();
        checks++;
        if (fsm_state !== PC_IDLE || redirect_valid !== 1'b0 || cnt_mispredict !== 4'd1) begin
            errors++; $display("FAIL ack_collision: got state %0d rv %b cnt %0d want 0 0 1",
                               fsm_state, redirect_valid, cnt_mispredict);
        end
        redirect_ack = 1'b0;
        tick();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_addr !== 32'h0000_0200 || cnt_mispredict !== 4'd2) begin
            errors++; $display("FAIL reaccept: got rv %b addr %h cnt %0d want 1 00000200 2",
                               redirect_valid, redirect_addr, cnt_mispredict);
        end
        idle_inputs();
        redirect_ack = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_in_redirect();
        do_reset();
        req_id = 1'b1;
        ex_mispredict = 1'b1;
        ex_target = 32'h0000_0abc;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || br !== 1'b0 || cnt_mispredict !== 4'd0 || cnt_stall !== 4'd0) begin
            errors++; $display("FAIL rst_redirect: got rv %b br %b cnt %0d/%0d want 0 0 0/0",
                               redirect_valid, br, cnt_mispredict, cnt_stall);
        end
        ex_mispredict = 1'b1;
        ex_target = 32'h0000_2000;
        tick();
        ex_mispredict = 1'b0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_addr !== 32'h0000_2000) begin
            errors++; $display("FAIL post_rst_redirect: got rv %b addr %h want 1 00002000",
                               redirect_valid, redirect_addr);
        end
        redirect_ack = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_mispredict_saturation();
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            ex_mispredict = 1'b1;
            ex_target = 32'h0000_4000 + n;
            redirect_ack = 1'b0;
            tick();
            ex_mispredict = 1'b0;
            redirect_ack = 1'b1;
            tick();
            if (n == 15) begin
                checks++;
                if (cnt_mispredict !== 4'hF) begin
                    errors++; $display("FAIL cnt_mp_15: got %h want F", cnt_mispredict);
                end
            end
        end
        checks++;
        if (cnt_mispredict !== 4'hF || cnt_stall !== 4'h0) begin
            errors++; $display("FAIL cnt_mp_sat: got %h/%h want F/0", cnt_mispredict, cnt_stall);
        end
        checks++;
        if (redirect_addr !== 32'h0000_4010) begin
            errors++; $display("FAIL sat_last_addr: got %h want 00004010", redirect_addr);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_stall_merge();
        test_stall_count();
        test_flush_sequence();
        test_mispredict_under_stall();
        test_back_to_back();
        test_reset_in_redirect();
        test_mispredict_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
